// File: rtl/i2c_pkg.sv
// Shared definitions for the display-link I2C target: FSM encoding and
// control-byte field positions.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_PAYLOAD,
        ST_PAYLOAD_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam int   CO_BIT      = 7;
    localparam int   DC_BIT      = 6;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchroniser for one bus line, followed by a history flop so that
// single-cycle rise/fall strobes can be derived from the synchronised level.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    // Reset to 1 (idle open-drain bus) so leaving reset creates no false edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
            hist_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~hist_reg;
    assign fall  = ~level & hist_reg;

endmodule

// File: rtl/i2c_target.sv
// I2C target for the display link: decodes address, control and payload
// bytes, ACKs its own traffic and serves status bytes on reads.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .din(scl_in),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .din(sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic       full_reg, full_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [7:0] tx_byte_reg, tx_byte_next;
    logic       rw_reg, rw_next;
    logic       co_reg, co_next;
    logic       dc_reg, dc_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       rx_valid_reg, rx_valid_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rx_dc_reg, rx_dc_next;
    logic       tx_req_reg, tx_req_next;
    logic       busy_reg, busy_next;

    logic       shifting;
    logic [7:0] shift_in;
    assign shifting = (state_reg == ST_ADDR) || (state_reg == ST_CTRL) ||
                      (state_reg == ST_PAYLOAD) || (state_reg == ST_RD_BYTE);
    assign shift_in = {shreg_reg[6:0], sda_lvl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd7;
            full_reg     <= 1'b0;
            shreg_reg    <= 8'h00;
            tx_byte_reg  <= 8'h00;
            rw_reg       <= 1'b0;
            co_reg       <= 1'b0;
            dc_reg       <= 1'b0;
            sda_oe_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= 8'h00;
            rx_dc_reg    <= 1'b0;
            tx_req_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            full_reg     <= full_next;
            shreg_reg    <= shreg_next;
            tx_byte_reg  <= tx_byte_next;
            rw_reg       <= rw_next;
            co_reg       <= co_next;
            dc_reg       <= dc_next;
            sda_oe_reg   <= sda_oe_next;
            rx_valid_reg <= rx_valid_next;
            rx_data_reg  <= rx_data_next;
            rx_dc_reg    <= rx_dc_next;
            tx_req_reg   <= tx_req_next;
            busy_reg     <= busy_next;
        end
    end

    // full_reg marks "8 bits sampled"; the byte is acted on at the next scl fall.
    always_comb begin
        state_next = state_reg;
        if (stop_det) begin
            state_next = ST_IDLE;
        end else if (start_det) begin
            state_next = ST_ADDR;
        end else begin
            case (state_reg)
                ST_ADDR:
                    if (scl_fall && full_reg)
                        state_next = (shreg_reg[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:
                    if (scl_fall)
                        state_next = (rw_reg == I2C_RW_READ) ? ST_RD_BYTE : ST_CTRL;
                ST_CTRL:
                    if (scl_fall && full_reg) state_next = ST_CTRL_ACK;
                ST_CTRL_ACK:
                    if (scl_fall) state_next = ST_PAYLOAD;
                ST_PAYLOAD:
                    if (scl_fall && full_reg) state_next = ST_PAYLOAD_ACK;
                ST_PAYLOAD_ACK:
                    if (scl_fall) state_next = co_reg ? ST_CTRL : ST_PAYLOAD;
                ST_RD_BYTE:
                    if (scl_fall && full_reg) state_next = ST_RD_ACK;
                ST_RD_ACK:
                    if (scl_rise && sda_lvl) state_next = ST_IGNORE;
                    else if (scl_fall && full_reg) state_next = ST_RD_BYTE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next  = bit_cnt_reg;
        full_next     = full_reg;
        shreg_next    = shreg_reg;
        tx_byte_next  = tx_byte_reg;
        rw_next       = rw_reg;
        co_next       = co_reg;
        dc_next       = dc_reg;
        sda_oe_next   = sda_oe_reg;
        rx_valid_next = 1'b0;
        rx_data_next  = rx_data_reg;
        rx_dc_next    = rx_dc_reg;
        tx_req_next   = 1'b0;
        busy_next     = busy_reg;
        if (stop_det) begin
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else if (start_det) begin
            sda_oe_next  = 1'b0;
            busy_next    = 1'b1;
            bit_cnt_next = 3'd7;
            full_next    = 1'b0;
        end else begin
            if (scl_rise && shifting) begin
                shreg_next = shift_in;
                if (bit_cnt_reg == 3'd0) full_next = 1'b1;
                else                     bit_cnt_next = bit_cnt_reg - 3'd1;
                if (state_reg == ST_PAYLOAD && bit_cnt_reg == 3'd0) begin
                    rx_valid_next = 1'b1;
                    rx_data_next  = shift_in;
                    rx_dc_next    = dc_reg;
                end
            end
            case (state_reg)
                ST_ADDR:
                    if (scl_fall && full_reg) begin
                        rw_next     = shreg_reg[0];
                        sda_oe_next = (shreg_reg[7:1] == TARGET_ADDR);
                    end
                ST_CTRL:
                    if (scl_fall && full_reg) begin
                        co_next     = shreg_reg[CO_BIT];
                        dc_next     = shreg_reg[DC_BIT];
                        sda_oe_next = 1'b1;
                    end
                ST_PAYLOAD:
                    if (scl_fall && full_reg) sda_oe_next = 1'b1;
                ST_ADDR_ACK, ST_CTRL_ACK, ST_PAYLOAD_ACK:
                    if (scl_fall) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 3'd7;
                        full_next    = 1'b0;
                        if (state_reg == ST_ADDR_ACK && rw_reg == I2C_RW_READ) begin
                            tx_req_next  = 1'b1;
                            tx_byte_next = tx_data;
                            sda_oe_next  = ~tx_data[7];
                        end
                    end
                ST_RD_BYTE:
                    if (scl_fall) begin
                        if (full_reg) begin
                            sda_oe_next = 1'b0;
                            full_next   = 1'b0;
                        end else begin
                            sda_oe_next = ~tx_byte_reg[bit_cnt_reg];
                        end
                    end
                ST_RD_ACK: begin
                    if (scl_rise && !sda_lvl) full_next = 1'b1;
                    if (scl_fall && full_reg) begin
                        tx_req_next  = 1'b1;
                        tx_byte_next = tx_data;
                        sda_oe_next  = ~tx_data[7];
                        bit_cnt_next = 3'd7;
                        full_next    = 1'b0;
                    end
                end
                ST_IGNORE: sda_oe_next = 1'b0;
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign rx_dc    = rx_dc_reg;
    assign tx_req   = tx_req_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master on a wired-AND bus with
// a scoreboard queue for received payload bytes and returned status bytes.
module tb_i2c_target;

    localparam int QC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl, sda;
    logic       sda_oe, rx_valid, rx_dc, tx_req, busy;
    logic [7:0] rx_data, tx_data;

    logic [7:0] tx_tab [0:2];
    int         tx_idx = 0;
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    bit         done = 1'b0;
    logic [8:0] exp_q [$];
    logic [7:0] rd_q  [$];

    assign scl     = scl_m;
    assign sda     = sda_m & ~sda_oe;
    assign tx_data = tx_tab[tx_idx];

    always #5 clk = ~clk;

    i2c_target dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda), .sda_oe(sda_oe),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_dc(rx_dc),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            rx_cnt++;
            if (exp_q.size() > 0) begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("rx_byte", {23'd0, rx_dc, rx_data}, {23'd0, e});
                $display("rx byte dc=%0d data=0x%02h expected dc=%0d data=0x%02h", rx_dc, rx_data, e[8], e[7:0]);
            end else begin
                n_assert++;
                n_fail++;
                $error("FAIL rx_extra: observed dc=%0d data=0x%02h expected no pulse", rx_dc, rx_data);
            end
        end
        if (!rst && tx_req) begin
            tx_cnt++;
            if (tx_idx < 2) tx_idx++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        if (!done) begin
            $display("FAIL watchdog: observed timeout expected end of test");
            $fatal(1, "watchdog expired");
        end
    end

    task automatic q();
        repeat (QC) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = sda; q();
        scl_m = 1'b0; q();
    endtask

    task automatic wb(input logic [7:0] v, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(a);
        $display("write 0x%02h ack_bit=%0d expected %0d (%s)", v, a, exp_ack, tag);
        check(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic rb(input logic master_ack, input string tag);
        logic [7:0] v;
        logic [7:0] e;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(~master_ack);
        e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
        $display("read 0x%02h expected 0x%02h (%s)", v, e, tag);
        check(tag, {24'd0, v}, {24'd0, e});
    endtask

    initial begin
        int base;
        tx_tab[0] = 8'h43;
        tx_tab[1] = 8'h07;
        tx_tab[2] = 8'hEE;
        repeat (4) @(negedge clk);
        check("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data",  {24'd0, rx_data},  32'd0);
        check("rst_rx_dc",    {31'd0, rx_dc},    32'd0);
        check("rst_tx_req",   {31'd0, tx_req},   32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        rst = 1'b0;
        q();

        // Command stream: one control byte with Co=0, three commands.
        base = rx_cnt;
        i2c_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        wb(8'h78, 1'b0, "t1_addr_ack");
        wb(8'h00, 1'b0, "t1_ctrl_ack");
        exp_q.push_back({1'b0, 8'hAE}); wb(8'hAE, 1'b0, "t1_b0_ack");
        exp_q.push_back({1'b0, 8'hD5}); wb(8'hD5, 1'b0, "t1_b1_ack");
        exp_q.push_back({1'b0, 8'h80}); wb(8'h80, 1'b0, "t1_b2_ack");
        i2c_stop();
        check("t1_busy_stop", {31'd0, busy}, 32'd0);
        check("t1_rx_cnt", rx_cnt - base, 32'd3);

        // Data stream: control byte 0x40 is not emitted.
        base = rx_cnt;
        i2c_start();
        wb(8'h78, 1'b0, "t2_addr_ack");
        wb(8'h40, 1'b0, "t2_ctrl_ack");
        exp_q.push_back({1'b1, 8'hFF}); wb(8'hFF, 1'b0, "t2_b0_ack");
        exp_q.push_back({1'b1, 8'h00}); wb(8'h00, 1'b0, "t2_b1_ack");
        i2c_stop();
        check("t2_rx_cnt", rx_cnt - base, 32'd2);

        // Co=1: each payload byte is preceded by its own control byte.
        base = rx_cnt;
        i2c_start();
        wb(8'h78, 1'b0, "t3_addr_ack");
        wb(8'h80, 1'b0, "t3_ctrl0_ack");
        exp_q.push_back({1'b0, 8'hAF}); wb(8'hAF, 1'b0, "t3_b0_ack");
        wb(8'hC0, 1'b0, "t3_ctrl1_ack");
        exp_q.push_back({1'b1, 8'h55}); wb(8'h55, 1'b0, "t3_b1_ack");
        i2c_stop();
        check("t3_rx_cnt", rx_cnt - base, 32'd2);

        // Foreign address: NACK, ignored until STOP.
        base = rx_cnt;
        i2c_start();
        wb(8'h7A, 1'b1, "t4_addr_nack");
        wb(8'h40, 1'b1, "t4_ignored_nack");
        check("t4_busy", {31'd0, busy}, 32'd1);
        check("t4_sda_oe", {31'd0, sda_oe}, 32'd0);
        i2c_stop();
        check("t4_busy_stop", {31'd0, busy}, 32'd0);
        check("t4_rx_cnt", rx_cnt - base, 32'd0);

        // Read two status bytes; master ACKs the first, NACKs the second.
        base = tx_cnt;
        rd_q.push_back(tx_tab[0]);
        rd_q.push_back(tx_tab[1]);
        i2c_start();
        wb(8'h79, 1'b0, "t5_addr_ack");
        rb(1'b1, "t5_rd0");
        rb(1'b0, "t5_rd1");
        q();
        check("t5_tx_req_cnt", tx_cnt - base, 32'd2);
        check("t5_ignore_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t5_ignore_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        check("t5_busy_stop", {31'd0, busy}, 32'd0);

        // Repeated START after 4 payload bits discards the partial byte.
        base = rx_cnt;
        i2c_start();
        wb(8'h78, 1'b0, "t6_addr_ack");
        wb(8'h40, 1'b0, "t6_ctrl_ack");
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_start();
        check("t6_rs_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t6_rs_busy", {31'd0, busy}, 32'd1);
        wb(8'h78, 1'b0, "t6_addr2_ack");
        wb(8'h40, 1'b0, "t6_ctrl2_ack");
        exp_q.push_back({1'b1, 8'h5A}); wb(8'h5A, 1'b0, "t6_b0_ack");
        i2c_stop();
        check("t6_rx_cnt", rx_cnt - base, 32'd1);

        // Reset while the target is driving the control-byte ACK.
        base = rx_cnt;
        i2c_start();
        wb(8'h78, 1'b0, "t7_addr_ack");
        for (int i = 7; i >= 0; i--) write_bit(i == 6);
        check("t7_ack_driven", {31'd0, sda_oe}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("t7_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t7_rst_busy", {31'd0, busy}, 32'd0);
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        q();
        scl_m = 1'b1;
        q();
        check("t7_rx_cnt", rx_cnt - base, 32'd0);

        // Recovery after reset.
        base = rx_cnt;
        i2c_start();
        wb(8'h78, 1'b0, "t8_addr_ack");
        wb(8'h40, 1'b0, "t8_ctrl_ack");
        exp_q.push_back({1'b1, 8'h12}); wb(8'h12, 1'b0, "t8_b0_ack");
        i2c_stop();
        check("t8_rx_cnt", rx_cnt - base, 32'd1);
        check("end_exp_q_empty", exp_q.size(), 32'd0);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
